// File: rtl/div_fp_pkg.sv
// Shared types and helpers for the iterative floating-point divider:
// FSM states, format widths and canonical special-value bit patterns.
package div_fp_pkg;

    typedef enum logic [1:0] {IDLE, DIVIDE, NORMALIZE, DONE} state_t;

    function automatic int fp_width(input int ew, input int mw);
        return 1 + ew + mw;
    endfunction

    function automatic int fp_bias(input int ew);
        return (1 << (ew - 1)) - 1;
    endfunction

    // Patterns are built on 64 bits; callers size-cast them to the word width.
    function automatic logic [63:0] sign_bit(input logic s, input int ew, input int mw);
        return {63'd0, s} << (ew + mw);
    endfunction

    function automatic logic [63:0] exp_ones(input int ew, input int mw);
        return ((64'd1 << ew) - 64'd1) << mw;
    endfunction

    function automatic logic [63:0] nan_pat(input logic s, input int ew, input int mw);
        return sign_bit(s, ew, mw) | exp_ones(ew, mw) | (64'd1 << (mw - 1));
    endfunction

    function automatic logic [63:0] inf_pat(input logic s, input int ew, input int mw);
        return sign_bit(s, ew, mw) | exp_ones(ew, mw);
    endfunction

    function automatic logic [63:0] zero_pat(input logic s, input int ew, input int mw);
        return sign_bit(s, ew, mw);
    endfunction

endpackage

// File: rtl/div_fp_classify.sv
// Combinational operand decode: sign, exponent, hidden-bit mantissa and class.
// Denormals are treated as zero; an all-ones exponent flags inf/NaN.
module div_fp_classify
    import div_fp_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    localparam int W = fp_width(EXP_W, MAN_W)
) (
    input  logic [W-1:0]     op,
    output logic             is_zero,
    output logic             is_special,
    output logic             sign,
    output logic [EXP_W-1:0] exp,
    output logic [MAN_W:0]   man
);

    assign sign       = op[W-1];
    assign exp        = op[MAN_W +: EXP_W];
    assign man        = {1'b1, op[MAN_W-1:0]};
    assign is_zero    = (exp == '0);
    assign is_special = &exp;

endmodule

// File: rtl/div_fp_iterative.sv
// Restoring radix-2 FP divider: one quotient bit per cycle, result MAN_W+3 edges after accept
// (specials resolve on the accept edge). Result held in DONE until i_Ready; o_Ready only in IDLE.
module div_fp_iterative
    import div_fp_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    localparam int W = fp_width(EXP_W, MAN_W)
) (
    input  logic         i_Clk,
    input  logic         i_Rst_n,
    input  logic         i_Valid,
    output logic         o_Ready,
    input  logic [W-1:0] i_Dividend,
    input  logic [W-1:0] i_Divisor,
    output logic         o_Valid,
    input  logic         i_Ready,
    output logic [W-1:0] o_Quotient,
    output logic         o_Exception
);

    localparam int CW = $clog2(MAN_W + 3);
    localparam logic [CW-1:0]           LAST   = CW'(MAN_W + 1);
    localparam logic [EXP_W+1:0]        BIAS_E = (EXP_W + 2)'(fp_bias(EXP_W));
    localparam logic signed [EXP_W+1:0] ONE    = (EXP_W + 2)'(1);
    localparam logic signed [EXP_W+1:0] ZERO   = (EXP_W + 2)'(0);
    localparam logic signed [EXP_W+1:0] EMAX   = (EXP_W + 2)'((1 << EXP_W) - 1);

    logic             a_zero, a_spec, a_sign;
    logic             b_zero, b_spec, b_sign;
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W:0]   a_man, b_man;

    div_fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
        .op(i_Dividend), .is_zero(a_zero), .is_special(a_spec),
        .sign(a_sign), .exp(a_exp), .man(a_man)
    );

    div_fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
        .op(i_Divisor), .is_zero(b_zero), .is_special(b_spec),
        .sign(b_sign), .exp(b_exp), .man(b_man)
    );

    state_t                  state;
    logic [MAN_W+1:0]        rem, quo;
    logic [MAN_W:0]          dsr;
    logic [CW-1:0]           cnt;
    logic signed [EXP_W+1:0] expo;
    logic                    sgn;

    logic                    res_sign, ge;
    logic [MAN_W+1:0]        rem_sub, rem_next;
    logic [EXP_W+1:0]        e_acc;
    logic signed [EXP_W+1:0] e_norm;
    logic [MAN_W-1:0]        m_norm;

    assign res_sign = a_sign ^ b_sign;
    assign e_acc    = {2'b00, a_exp} - {2'b00, b_exp} + BIAS_E;
    assign ge       = (rem >= {1'b0, dsr});
    assign rem_sub  = ge ? (rem - {1'b0, dsr}) : rem;
    assign rem_next = rem_sub << 1;

    // A quotient below 1.0 has its integer bit clear; use the next bit as the leading one.
    assign e_norm = quo[MAN_W+1] ? expo : (expo - ONE);
    assign m_norm = quo[MAN_W+1] ? quo[MAN_W:1] : quo[MAN_W-1:0];

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state       <= IDLE;
            o_Ready     <= 1'b1;
            o_Valid     <= 1'b0;
            o_Quotient  <= '0;
            o_Exception <= 1'b0;
            rem         <= '0;
            quo         <= '0;
            dsr         <= '0;
            cnt         <= '0;
            expo        <= '0;
            sgn         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_Valid) begin
                        o_Ready <= 1'b0;
                        sgn     <= res_sign;
                        if (a_spec || b_spec) begin
                            o_Quotient  <= W'(nan_pat(res_sign, EXP_W, MAN_W));
                            o_Exception <= 1'b1;
                            o_Valid     <= 1'b1;
                            state       <= DONE;
                        end else if (b_zero) begin
                            o_Quotient  <= W'(inf_pat(res_sign, EXP_W, MAN_W));
                            o_Exception <= 1'b1;
                            o_Valid     <= 1'b1;
                            state       <= DONE;
                        end else if (a_zero) begin
                            o_Quotient  <= W'(zero_pat(res_sign, EXP_W, MAN_W));
                            o_Exception <= 1'b0;
                            o_Valid     <= 1'b1;
                            state       <= DONE;
                        end else begin
                            rem   <= {1'b0, a_man};
                            dsr   <= b_man;
                            quo   <= '0;
                            cnt   <= '0;
                            expo  <= e_acc;
                            state <= DIVIDE;
                        end
                    end
                end
                DIVIDE: begin
                    rem <= rem_next;
                    quo <= {quo[MAN_W:0], ge};
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state <= NORMALIZE;
                    end
                end
                NORMALIZE: begin
                    o_Valid <= 1'b1;
                    state   <= DONE;
                    if (e_norm >= EMAX) begin
                        o_Quotient  <= W'(inf_pat(sgn, EXP_W, MAN_W));
                        o_Exception <= 1'b1;
                    end else if (e_norm <= ZERO) begin
                        o_Quotient  <= W'(zero_pat(sgn, EXP_W, MAN_W));
                        o_Exception <= 1'b1;
                    end else begin
                        o_Quotient  <= {sgn, e_norm[EXP_W-1:0], m_norm};
                        o_Exception <= 1'b0;
                    end
                end
                DONE: begin
                    if (i_Ready) begin
                        o_Valid <= 1'b0;
                        o_Ready <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_fp_iterative.sv
// Scoreboard bench for div_fp_iterative: driver queues expected results, monitor checks on output.
module tb_div_fp_iterative;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_vld, out_rdy, in_rdy, out_vld, out_exc;
    logic [15:0] dvd, dvs, quot;

    always #5 clk = ~clk;

    div_fp_iterative dut (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Valid(in_vld), .o_Ready(out_rdy),
        .i_Dividend(dvd), .i_Divisor(dvs), .o_Valid(out_vld), .i_Ready(in_rdy),
        .o_Quotient(quot), .o_Exception(out_exc)
    );

    typedef struct {
        logic [15:0] q;
        logic        exc;
        int          lat;
        int          acc;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic        exc;
        int          lat;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[13];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Latency is counted in edges after the accept edge; specials resolve on the accept edge.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [15:0] q,
                         input logic exc, input int lat, input bit push);
        exp_t e;
        int   t = 0;
        while (!out_rdy && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("ready_before_issue", out_rdy, 1);
        in_vld = 1'b1;
        dvd    = a;
        dvs    = b;
        @(posedge clk);
        #1;
        if (push) begin
            e.q = q; e.exc = exc; e.lat = lat; e.acc = cyc;
            sb.push_back(e);
        end
        in_vld = 1'b0;
        dvd    = 16'($urandom);
        dvs    = 16'($urandom);
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && out_vld) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got quotient %h, expected no result", quot);
                end else begin
                    chk("quotient", quot, sb[0].q);
                    chk("exception", out_exc, sb[0].exc);
                    chk("ready_low_in_done", out_rdy, 0);
                    if (!prev) chk("latency", cyc - sb[0].acc, sb[0].lat);
                    if (in_rdy) void'(sb.pop_front());
                end
            end
            prev = rst_n && out_vld;
        end
    end

    initial begin
        int t;
        vecs[0]  = '{16'h3C00, 16'h4000, 16'h3800, 1'b0, 13};
        vecs[1]  = '{16'h4500, 16'h4000, 16'h4100, 1'b0, 13};
        vecs[2]  = '{16'h3C00, 16'h4200, 16'h3555, 1'b0, 13};
        vecs[3]  = '{16'hC000, 16'h4000, 16'hBC00, 1'b0, 13};
        vecs[4]  = '{16'h3C00, 16'h0000, 16'h7C00, 1'b1, 0};
        vecs[5]  = '{16'h3C00, 16'h0001, 16'h7C00, 1'b1, 0};
        vecs[6]  = '{16'h0000, 16'h4000, 16'h0000, 1'b0, 0};
        vecs[7]  = '{16'h7E00, 16'h3C00, 16'h7E00, 1'b1, 0};
        vecs[8]  = '{16'h7800, 16'h0C00, 16'h7C00, 1'b1, 13};
        vecs[9]  = '{16'h0C00, 16'h7800, 16'h0000, 1'b1, 13};
        vecs[10] = '{16'h3C00, 16'hFC00, 16'hFE00, 1'b1, 0};
        vecs[11] = '{16'h8000, 16'h4000, 16'h8000, 1'b0, 0};
        vecs[12] = '{16'h7C00, 16'h0000, 16'h7E00, 1'b1, 0};

        rst_n   = 1'b0;
        in_vld  = 1'b0;
        in_rdy  = 1'b1;
        dvd     = '0;
        dvs     = '0;
        #12;
        chk("reset_valid", out_vld, 0);
        chk("reset_quotient", quot, 0);
        chk("reset_exception", out_exc, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ready", out_rdy, 1);

        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].exc, vecs[i].lat, 1'b1);
            drain();
        end

        // Consumer stall: result must hold while new operands are waved at the input.
        in_rdy = 1'b0;
        issue(16'h3C00, 16'h4000, 16'h3800, 1'b0, 13, 1'b1);
        t = 0;
        while (!out_vld && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("stall_valid_seen", out_vld, 1);
        repeat (5) begin
            @(posedge clk);
            #1;
            in_vld = 1'b1;
            dvd    = 16'($urandom);
            dvs    = 16'($urandom);
        end
        in_vld = 1'b0;
        in_rdy = 1'b1;
        drain();

        // Reset in the middle of a division aborts it.
        issue(16'h4500, 16'h4000, 16'h4100, 1'b0, 13, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_valid", out_vld, 0);
        chk("abort_quotient", quot, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("abort_no_result", out_vld, 0);
        chk("abort_ready", out_rdy, 1);
        issue(16'h3C00, 16'h4200, 16'h3555, 1'b0, 13, 1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_fp_iterative.md
DIV_FP_ITERATIVE -- requirements
Module: div_fp_iterative

Interface
REQ-001 Parameter EXP_W, default 5, exponent field width.
REQ-002 Parameter MAN_W, default 10, stored mantissa field width; W = 1+EXP_W+MAN_W (16 at defaults); BIAS = 2^(EXP_W-1)-1.
REQ-003 i_Clk  input  1  single clock, all state on rising edge.
REQ-004 i_Rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_Valid  input  1  operands present.
REQ-006 o_Ready  output  1  block can accept operands.
REQ-007 i_Dividend  input  W  sign|exponent|mantissa dividend.
REQ-008 i_Divisor  input  W  sign|exponent|mantissa divisor.
REQ-009 o_Valid  output  1  result present.
REQ-010 i_Ready  input  1  consumer accepts result.
REQ-011 o_Quotient  output  W  quotient, same format as inputs.
REQ-012 o_Exception  output  1  result is inf/NaN/flushed underflow, qualified by o_Valid.

Function
REQ-013 States IDLE, DIVIDE, NORMALIZE, DONE; o_Ready SHALL be 1 only in IDLE.
REQ-014 Accept on i_Valid&&o_Ready at a rising edge; operands registered at that edge; IDLE->DIVIDE, or IDLE->DONE for special cases.
REQ-015 Classification: exp==0 (any mantissa) = zero (denormals flushed); exp==all-ones = inf/NaN.
REQ-016 Special cases, priority order: either operand inf/NaN -> quotient {sign,all-ones exp,MSB-only mantissa} (canonical NaN), exception 1; divisor zero -> {sign,all-ones exp,0} (inf), exception 1; dividend zero -> {sign,0,0}, exception 0.
REQ-017 Result sign = XOR of operand signs in all cases, including NaN.
REQ-018 DIVIDE: restoring radix-2 division of 1.m1 by 1.m2, one quotient bit per cycle, exactly MAN_W+2 cycles, producing quotient q in [0.5,2) with 1 integer and MAN_W+1 fraction bits.
REQ-019 Exponent: e = e1 - e2 + BIAS computed signed on EXP_W+2 bits during DIVIDE.
REQ-020 NORMALIZE (1 cycle): if q integer bit 0, shift q left 1 and e = e-1; mantissa = next MAN_W bits, truncated (round toward zero).
REQ-021 Overflow: e >= 2^EXP_W-1 after normalize -> signed inf, exception 1; underflow: e <= 0 -> signed zero, exception 1.
REQ-022 Latency: o_Valid rises MAN_W+3 edges after accept edge (13 at defaults); special cases 1 edge.
REQ-023 DONE: o_Valid=1, o_Quotient/o_Exception stable until i_Valid-independent handshake o_Valid&&i_Ready, then ->IDLE next edge.
REQ-024 No new operand accepted in the handshake cycle; i_Dividend/i_Divisor changes after accept SHALL NOT affect result.

Reset
REQ-025 i_Rst_n low SHALL immediately force IDLE, o_Ready=1 once released, o_Valid=0, o_Quotient=0, o_Exception=0.
REQ-026 Reset mid-DIVIDE/NORMALIZE/DONE SHALL abort the operation; no result delivered after release.

Structure
REQ-027 Package div_fp_pkg SHALL hold the state enum, W/BIAS derivation functions, and canonical NaN/inf/zero pattern functions.
REQ-028 One sub-module div_fp_classify (combinational, per operand: is_zero, is_special, sign, exp, 1.m) instantiated twice.
REQ-029 Datapath registers: remainder MAN_W+2 bits, quotient MAN_W+2 bits, iteration counter ceil(log2(MAN_W+3)) bits, exponent EXP_W+2 bits.

Verification
REQ-030 0x3C00 / 0x4000 -> 0x3800, exception 0, o_Valid 13 cycles after accept; 0x4500 / 0x4000 -> 0x4100.
REQ-031 0x3C00 / 0x4200 -> 0x3555 (normalize path, truncation); 0xC000 / 0x4000 -> 0xBC00.
REQ-032 0x3C00 / 0x0000 and 0x3C00 / 0x0001 -> 0x7C00, exception 1, latency 1; 0x0000 / 0x4000 -> 0x0000, exception 0; 0x7E00 / 0x3C00 -> 0x7E00, exception 1.
REQ-033 0x7800 / 0x0C00 -> 0x7C00 exception 1 (overflow); 0x0C00 / 0x7800 -> 0x0000 exception 1 (underflow).
REQ-034 i_Ready held 0 for 5 cycles in DONE -> o_Quotient/o_Exception unchanged, o_Ready 0; input changes ignored.
REQ-035 i_Rst_n pulsed low at DIVIDE cycle 4 -> o_Valid 0 immediately, no result delivered, next operation correct.
